four_bit_deserializer: RTL
==========================

Name: four_bit_deserializer

Overview:
Serial-to-parallel receiver that rebuilds WIDTH-bit words from a one-bit-per-beat serial stream. It is the receive-side counterpart to the shift/rotate datapath: it shifts incoming bits into a register, either LSB-first (right shift) or MSB-first (left shift). Each completed word is presented on R with a valid/ready handshake. The block sits between a serial link front end and the parallel ALU/shifter datapath.

Parameters:
WIDTH, 4, word length in bits; legal range 2..16.
CNTW, 3, width of the bit counter; must satisfy 2**CNTW > WIDTH.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
SerIn  input  1  serial data bit.
SerValid  input  1  SerIn carries a bit this cycle.
SerReady  output  1  block can accept a bit this cycle.
Mode  input  1  0 = LSB-first (right shift, new bit into MSB); 1 = MSB-first (left shift, new bit into bit 0).
Clear  input  1  synchronous flush of a partially received word.
R  output  WIDTH  assembled word.
RValid  output  1  R holds a complete, unconsumed word.
RReady  input  1  consumer accepts R this cycle.
BitCnt  output  CNTW  number of bits received in the current partial word.
Overrun  output  1  sticky error flag.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: R=0, RValid=0, BitCnt=0, Overrun=0, shift register=0, state=IDLE.
- Beat: a bit is accepted when SerValid && SerReady at the rising edge.
- Ready rule: SerReady = ~RValid | RReady.
  - A bit can be accepted in the same cycle that a held word is consumed.
  - SerReady never depends on SerValid.
- States:
  - IDLE: BitCnt=0.
  - SHIFT: 0<BitCnt<WIDTH.
  - No separate HOLD state; RValid is its own register.
- IDLE->SHIFT: on the first accepted bit. Mode is sampled and latched for the whole word on that beat. Mode changes mid-word are ignored.
- LSB-first step: sr <= {SerIn, sr[WIDTH-1:1]}. After WIDTH bits, the first bit received sits in R[0].
- MSB-first step: sr <= {sr[WIDTH-2:0], SerIn}. After WIDTH bits, the first bit received sits in R[WIDTH-1].
- Word completion: on the beat that accepts bit WIDTH:
  - R <= final shifted value.
  - RValid <= 1.
  - BitCnt <= 0 and state <= IDLE in the same edge.
  - Latency: R and RValid are valid the cycle after the last bit's edge.
- Consume: RValid && RReady at an edge clears RValid, unless a new word completes on that same edge, in which case RValid stays 1 and R takes the new word.
- R is stable while RValid=1 and not consumed.
- Backpressure: while RValid=1 and RReady=0, SerReady=0. No bits are accepted and the partial word plus BitCnt freeze.
- Overrun: set if SerValid=1 while SerReady=0. It stays set until reset and does not block operation.
- Clear:
  - Sets BitCnt=0, state=IDLE, sr=0.
  - Any bit presented in the same cycle is dropped.
  - R, RValid and Overrun are unaffected.
- Priority: reset > Clear > bit accept. Consume proceeds independently of Clear.
- Reset mid-word: the partial word is discarded and all outputs return to reset values on the next edge.
- BitCnt arithmetic: unsigned; it never exceeds WIDTH-1 on the output.

Test Plan:
- LSB-first: Mode=0, bits 1,0,1,1 on consecutive cycles, RReady=1 -> one cycle after 4th bit R=4'b1101, RValid=1 for one cycle.
- MSB-first: Mode=1, bits 1,0,1,1 -> R=4'b1011. Toggling Mode to 0 after the 2nd bit still yields 4'b1011.
- Backpressure: complete word 4'hA with RReady=0, then stream bits -> SerReady=0, Overrun=1, R stays 4'hA. Then raise RReady with SerValid=1 -> bit accepted the same cycle, BitCnt=1 next cycle.
- Back-to-back: 8 continuous bits with RReady tied high, Mode=0, bits 0,1,1,0,1,1,1,1 -> R=4'h6 then R=4'hF, no gap and no Overrun.
- Clear: after 2 bits assert Clear with SerValid=1 -> BitCnt=0 and that bit dropped. The next 4 bits 1,1,1,1 give R=4'hF. A previously held R is unchanged during Clear.
- Reset: reset asserted after 3 bits -> next edge BitCnt=0, RValid=0, R=0, Overrun=0. A subsequent full word assembles correctly.

Source files
------------

// File: rtl/four_bit_deserializer.sv
// Serial-to-parallel receiver: rebuilds WIDTH-bit words from a one-bit-per-beat stream,
// LSB-first or MSB-first, and presents each finished word on R with a valid/ready handshake.
module four_bit_deserializer #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SerIn,
    input  logic             SerValid,
    output logic             SerReady,
    input  logic             Mode,
    input  logic             Clear,
    output logic [WIDTH-1:0] R,
    output logic             RValid,
    input  logic             RReady,
    output logic [CNTW-1:0]  BitCnt,
    output logic             Overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_sr, w_sr_next;
    logic [WIDTH-1:0] r_word, w_word_next;
    logic [CNTW-1:0]  r_cnt, w_cnt_next;
    logic             r_mode, w_mode_next;
    logic             r_valid, w_valid_next;
    logic             r_overrun;

    logic             w_ready;
    logic             w_accept;
    logic             w_mode_eff;
    logic             w_last;
    logic [WIDTH-1:0] w_shifted;

    assign w_ready    = ~r_valid | RReady;
    assign w_accept   = SerValid & w_ready & ~Clear;
    // The first bit of a word uses the live Mode; later bits use the copy latched on that beat.
    assign w_mode_eff = (r_state == IDLE) ? Mode : r_mode;
    assign w_shifted  = w_mode_eff ? {r_sr[WIDTH-2:0], SerIn} : {SerIn, r_sr[WIDTH-1:1]};
    assign w_last     = w_accept && (r_cnt == CNTW'(WIDTH - 1));

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned (no latch).
        w_state_next = r_state;
        w_sr_next    = r_sr;
        w_word_next  = r_word;
        w_cnt_next   = r_cnt;
        w_mode_next  = r_mode;
        w_valid_next = r_valid;

        if (Clear) begin
            w_state_next = IDLE;
            w_sr_next    = '0;
            w_cnt_next   = '0;
        end else if (w_accept) begin
            w_mode_next = w_mode_eff;
            if (w_last) begin
                w_word_next  = w_shifted;
                w_sr_next    = '0;
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end else begin
                w_sr_next    = w_shifted;
                w_cnt_next   = r_cnt + CNTW'(1);
                w_state_next = SHIFT;
            end
        end

        // Consume is independent of Clear; a word completing on the same edge keeps RValid high.
        if (w_last) begin
            w_valid_next = 1'b1;
        end else if (r_valid && RReady) begin
            w_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state   <= IDLE;
            r_sr      <= '0;
            r_word    <= '0;
            r_cnt     <= '0;
            r_mode    <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sr    <= w_sr_next;
            r_word  <= w_word_next;
            r_cnt   <= w_cnt_next;
            r_mode  <= w_mode_next;
            r_valid <= w_valid_next;
            if (SerValid && !w_ready) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign SerReady = w_ready;
    assign R        = r_word;
    assign RValid   = r_valid;
    assign BitCnt   = r_cnt;
    assign Overrun  = r_overrun;

endmodule
